// File: rtl/nukv_response_pack_if.sv
// Handshake bundle for nukv_response_pack: meta and value inputs, 128-bit AXI-Stream output, error flag.
// The slave modport is the packer's view; the master modport is the view of whatever surrounds it.
interface nukv_response_pack_if #(
    parameter int META_WIDTH  = 96,
    parameter int VALUE_WIDTH = 512
);
    logic [META_WIDTH-1:0]  meta_data;
    logic                   meta_valid;
    logic                   meta_ready;
    logic [VALUE_WIDTH-1:0] value_data;
    logic                   value_valid;
    logic                   value_last;
    logic                   value_ready;
    logic [127:0]           m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tlast;
    logic                   m_axis_tready;
    logic                   err_sticky;

    modport slave (
        input  meta_data, meta_valid,
        output meta_ready,
        input  value_data, value_valid, value_last,
        output value_ready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready,
        output err_sticky
    );

    modport master (
        output meta_data, meta_valid,
        input  meta_ready,
        output value_data, value_valid, value_last,
        input  value_ready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready,
        input  err_sticky
    );
endinterface

// File: rtl/nukv_response_pack.sv
// Response packer: one header beat from the meta word, then vallen 64-bit value words, tlast on the final beat.
// Define RESP_ERRCHECK_EN to zero-pad short values, drain long ones and raise err_sticky.
module nukv_response_pack #(
    parameter int META_WIDTH  = 96,
    parameter int VALUE_WIDTH = 512
) (
    input logic                 clk,
    input logic                 rst,
    nukv_response_pack_if.slave bus
);
    localparam int WPB   = VALUE_WIDTH / 64;
    localparam int POS_W = $clog2(WPB);
    localparam int CNT_W = POS_W + 1;

`ifdef RESP_ERRCHECK_EN
    typedef enum logic [1:0] {ST_IDLE, ST_VALUE, ST_DRAIN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_VALUE} state_t;
`endif

    state_t                 state;
    logic                   adv, meta_fire, value_fire, emit, pad;
    logic [15:0]            words_left;
    logic [VALUE_WIDTH-1:0] beat_buf;
    logic [CNT_W-1:0]       buf_cnt, load_cnt;
    logic [POS_W-1:0]       pos;
    logic [63:0]            word;
    logic [7:0]             m_opcode;
    logic [15:0]            m_vallen;
    logic [63:0]            m_net;
    logic [127:0]           out_data;
    logic                   out_valid, out_last;
    logic                   unused_bits;
`ifdef RESP_ERRCHECK_EN
    logic                   last_beat, err;
`endif

    always_comb begin
        m_opcode = bus.meta_data[META_WIDTH-1 -: 8];
        m_vallen = bus.meta_data[META_WIDTH-17 -: 16];
        m_net    = bus.meta_data[63:0];
        adv      = ~out_valid | bus.m_axis_tready;
`ifdef RESP_ERRCHECK_EN
        // value ended early: keep emitting zero words until vallen is reached
        pad = (state == ST_VALUE) & last_beat & (buf_cnt == '0) & (words_left != 16'd0);
`else
        pad = 1'b0;
`endif
        word     = pad ? 64'h0 : beat_buf[{pos, 6'd0} +: 64];
        load_cnt = (words_left >= 16'(WPB)) ? CNT_W'(WPB) : CNT_W'(words_left);
        emit     = (state == ST_VALUE) & ((buf_cnt != '0) | pad) & adv;
    end

    assign bus.meta_ready  = ~rst & (state == ST_IDLE) & adv;
`ifdef RESP_ERRCHECK_EN
    assign bus.value_ready = ~rst & (((state == ST_VALUE) & (buf_cnt == '0) & ~pad) | (state == ST_DRAIN));
    assign bus.err_sticky  = err;
    assign unused_bits     = ^bus.meta_data[META_WIDTH-9 -: 8];
`else
    assign bus.value_ready = ~rst & (state == ST_VALUE) & (buf_cnt == '0);
    assign bus.err_sticky  = 1'b0;
    assign unused_bits     = ^{bus.meta_data[META_WIDTH-9 -: 8], bus.value_last};
`endif
    assign meta_fire  = bus.meta_valid & bus.meta_ready;
    assign value_fire = bus.value_valid & bus.value_ready;

    assign bus.m_axis_tdata  = out_data;
    assign bus.m_axis_tvalid = out_valid;
    assign bus.m_axis_tlast  = out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            buf_cnt    <= '0;
            pos        <= '0;
            words_left <= '0;
`ifdef RESP_ERRCHECK_EN
            last_beat  <= 1'b0;
            err        <= 1'b0;
`endif
        end else begin
            if (adv) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (meta_fire) begin
                        out_data   <= {m_net, m_opcode, 8'h00, m_vallen, 16'h0000, 16'hFFFF};
                        out_valid  <= 1'b1;
                        out_last   <= (m_vallen == 16'd0);
                        words_left <= m_vallen;
`ifdef RESP_ERRCHECK_EN
                        last_beat  <= 1'b0;
`endif
                        if (m_vallen != 16'd0) state <= ST_VALUE;
                    end
                end
                ST_VALUE: begin
                    if (value_fire) begin
                        beat_buf <= bus.value_data;
                        buf_cnt  <= load_cnt;
                        pos      <= '0;
`ifdef RESP_ERRCHECK_EN
                        last_beat <= bus.value_last;
                        if (bus.value_last && (words_left > 16'(WPB))) err <= 1'b1;
`endif
                    end else if (emit) begin
                        out_data   <= {64'h0, word};
                        out_valid  <= 1'b1;
                        out_last   <= (words_left == 16'd1);
                        pos        <= pos + 1'b1;
                        words_left <= words_left - 16'd1;
                        if (buf_cnt != '0) buf_cnt <= buf_cnt - 1'b1;
                        // final word: any unused tail of the buffered beat is dropped
                        if (words_left == 16'd1) begin
                            buf_cnt <= '0;
`ifdef RESP_ERRCHECK_EN
                            if (last_beat) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DRAIN;
                                err   <= 1'b1;
                            end
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef RESP_ERRCHECK_EN
                ST_DRAIN: begin
                    if (value_fire && bus.value_last) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
